// File: rtl/pipe_hazard_ctrl_seq.sv
// Sequential hazard/control unit for the 5-stage Y86-64 pipeline.
// Adds a data-memory wait freeze with timeout, a sticky HALTED state
// and saturating hazard performance counters.
module pipe_hazard_ctrl_seq #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned STAT_W   = 3,
  parameter logic [3:0]  I_RET    = 4'h9,
  parameter logic [3:0]  I_MRMOV  = 4'h5,
  parameter logic [3:0]  I_POP    = 4'hB,
  parameter logic [3:0]  I_JXX    = 4'h7,
  parameter logic [3:0]  R_NONE   = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_dstM,
  input  logic              e_Cnd,
  input  logic [3:0]        M_icode,
  input  logic              m_req,
  input  logic              m_ready,
  input  logic [STAT_W-1:0] m_stat,
  input  logic [STAT_W-1:0] W_stat,
  input  logic              clr_cnt,
  output logic              F_stall,
  output logic              D_stall,
  output logic              E_stall,
  output logic              M_stall,
  output logic              W_stall,
  output logic              D_bubble,
  output logic              E_bubble,
  output logic              M_bubble,
  output logic              halted,
  output logic              mem_timeout,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  lu_cnt,
  output logic [CNT_W-1:0]  mp_cnt
);

  localparam int unsigned WCNT_W = 8;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_halted;
  logic              r_timeout;
  logic [WCNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_lu_cnt;
  logic [CNT_W-1:0]  r_mp_cnt;

  logic w_ret, w_lu, w_mp, w_exc_m, w_exc_w, w_freeze;
  logic w_fs, w_ds, w_es, w_ms, w_ws, w_db, w_eb, w_mb;

  // Raw hazard terms
  assign w_ret   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign w_lu    = ((E_icode == I_MRMOV) || (E_icode == I_POP)) && (E_dstM != R_NONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign w_mp    = (E_icode == I_JXX) && !e_Cnd;
  assign w_exc_m = (m_stat >= STAT_W'(2)) && (m_stat <= STAT_W'(4));
  assign w_exc_w = (W_stat >= STAT_W'(2)) && (W_stat <= STAT_W'(4));

  // Freeze is the unreleased memory wait; a W exception in RUN overrides it
  assign w_freeze = (r_state == S_WAIT) ? !m_ready : (m_req && !m_ready && !w_exc_w);

  // Stage control selection by state
  always_comb begin
    w_fs = 1'b0; w_ds = 1'b0; w_es = 1'b0; w_ms = 1'b0; w_ws = 1'b0;
    w_db = 1'b0; w_eb = 1'b0; w_mb = 1'b0;
    if (r_state == S_HALT) begin
      {w_fs, w_ds, w_es, w_ms, w_ws} = 5'b11111;
      w_mb = 1'b1;
    end else if (w_freeze) begin
      {w_fs, w_ds, w_es, w_ms, w_ws} = 5'b11111;
    end else begin
      w_fs = w_lu | w_ret;
      w_ds = w_lu;
      w_db = w_mp | (w_ret & !w_lu);
      w_eb = w_mp | w_lu;
      w_mb = w_exc_m | w_exc_w;
      w_ws = w_exc_w;
    end
  end

  // Stage controls are held inactive while reset is asserted
  assign F_stall  = rst_n & w_fs;
  assign D_stall  = rst_n & w_ds;
  assign E_stall  = rst_n & w_es;
  assign M_stall  = rst_n & w_ms;
  assign W_stall  = rst_n & w_ws;
  assign D_bubble = rst_n & w_db;
  assign E_bubble = rst_n & w_eb;
  assign M_bubble = rst_n & w_mb;

  // FSM, wait counter, sticky flags and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_halted    <= 1'b0;
      r_timeout   <= 1'b0;
      r_wcnt      <= '0;
      r_stall_cnt <= '0;
      r_lu_cnt    <= '0;
      r_mp_cnt    <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_exc_w) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (w_freeze) begin
            r_wcnt <= WCNT_W'(1);
            if (WAIT_MAX <= 1) begin
              r_state   <= S_HALT;
              r_halted  <= 1'b1;
              r_timeout <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (m_ready) begin
            r_state <= S_RUN;
            r_wcnt  <= '0;
          end else if (r_wcnt >= WAIT_LAST) begin
            r_state   <= S_HALT;
            r_halted  <= 1'b1;
            r_timeout <= 1'b1;
            r_wcnt    <= r_wcnt + WCNT_W'(1);
          end else begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
          end
        end
        default: begin
          r_state  <= S_HALT;
          r_halted <= 1'b1;
        end
      endcase

      if (clr_cnt) begin
        r_stall_cnt <= '0;
        r_lu_cnt    <= '0;
        r_mp_cnt    <= '0;
      end else if (r_state != S_HALT) begin
        if (w_fs && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        if ((r_state == S_RUN) && w_lu && (r_lu_cnt != '1)) r_lu_cnt <= r_lu_cnt + CNT_W'(1);
        if ((r_state == S_RUN) && w_mp && (r_mp_cnt != '1)) r_mp_cnt <= r_mp_cnt + CNT_W'(1);
      end
    end
  end

  assign halted      = r_halted;
  assign mem_timeout = r_timeout;
  assign state       = r_state;
  assign stall_cnt   = r_stall_cnt;
  assign lu_cnt      = r_lu_cnt;
  assign mp_cnt      = r_mp_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl_seq.sv
// Directed self-checking bench for pipe_hazard_ctrl_seq (CNT_W=4, WAIT_MAX=4).
module tb_pipe_hazard_ctrl_seq;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 3;

  logic              clk;
  logic              rst_n;
  logic [3:0]        D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic              e_Cnd, m_req, m_ready, clr_cnt;
  logic [STAT_W-1:0] m_stat, W_stat;
  logic              F_stall, D_stall, E_stall, M_stall, W_stall;
  logic              D_bubble, E_bubble, M_bubble, halted, mem_timeout;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cnt, lu_cnt, mp_cnt;
  logic [7:0]        ctl;

  int n_chk;
  int n_fail;

  pipe_hazard_ctrl_seq #(.CNT_W(CNT_W), .WAIT_MAX(4), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_req(m_req), .m_ready(m_ready), .m_stat(m_stat), .W_stat(W_stat),
    .clr_cnt(clr_cnt),
    .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .halted(halted), .mem_timeout(mem_timeout), .state(state),
    .stall_cnt(stall_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt)
  );

  // Order: F,D,E,M,W stall then D,E,M bubble
  assign ctl = {F_stall, D_stall, E_stall, M_stall, W_stall, D_bubble, E_bubble, M_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_idle();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b1;
    m_req = 1'b0; m_ready = 1'b0; m_stat = 3'd1; W_stat = 3'd1; clr_cnt = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    set_idle();
    D_icode = 4'h9;
    rst_n = 1'b0;
    #12;
    chk("rst_ctl", 16'(ctl), 16'h00);
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_tmo", 16'(mem_timeout), 16'd0);
    chk("rst_cnts", 16'({stall_cnt, lu_cnt, mp_cnt}), 16'h000);
    D_icode = 4'h1;
    rst_n = 1'b1;
    tick(1);

    // Load-use via srcA
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1;
    chk("lu_ctl", 16'(ctl), 16'b11000_010);
    chk("lu_cnt0", 16'(lu_cnt), 16'd0);
    tick(1);
    chk("lu_cnt1", 16'(lu_cnt), 16'd1);
    chk("lu_stall1", 16'(stall_cnt), 16'd1);

    // R_NONE never hazards
    E_dstM = 4'hF; d_srcA = 4'hF;
    #1;
    chk("rnone_ctl", 16'(ctl), 16'h00);
    tick(1);
    chk("rnone_lu", 16'(lu_cnt), 16'd1);

    // Load-use via srcB together with ret
    E_dstM = 4'h3; d_srcB = 4'h3; D_icode = 4'h9;
    #1;
    chk("luret_ctl", 16'(ctl), 16'b11000_010);
    tick(1);
    chk("luret_lu", 16'(lu_cnt), 16'd2);
    chk("luret_stall", 16'(stall_cnt), 16'd2);

    // Mispredict together with ret
    set_idle();
    E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
    #1;
    chk("mpret_ctl", 16'(ctl), 16'b10000_110);
    tick(1);
    chk("mp_cnt1", 16'(mp_cnt), 16'd1);
    chk("mp_stall", 16'(stall_cnt), 16'd3);

    // Taken jump: ret only
    e_Cnd = 1'b1;
    #1;
    chk("ret_ctl", 16'(ctl), 16'b10000_100);
    tick(1);
    chk("ret_mp", 16'(mp_cnt), 16'd1);
    chk("ret_stall", 16'(stall_cnt), 16'd4);

    // M-stage exception range boundaries
    set_idle();
    m_stat = 3'd2;
    #1;
    chk("excm2_ctl", 16'(ctl), 16'b00000_001);
    m_stat = 3'd5;
    #1;
    chk("excm5_ctl", 16'(ctl), 16'h00);
    m_stat = 3'd1;

    // Counter clear
    clr_cnt = 1'b1;
    tick(1);
    chk("clr_cnts", 16'({stall_cnt, lu_cnt, mp_cnt}), 16'h000);
    clr_cnt = 1'b0;

    // Memory wait of three cycles, then release
    m_req = 1'b1;
    #1;
    chk("mw1_ctl", 16'(ctl), 16'b11111_000);
    chk("mw1_state", 16'(state), 16'd0);
    tick(1);
    chk("mw2_state", 16'(state), 16'd1);
    chk("mw2_ctl", 16'(ctl), 16'b11111_000);
    tick(2);
    chk("mw3_state", 16'(state), 16'd1);
    m_ready = 1'b1;
    #1;
    chk("mwrel_ctl", 16'(ctl), 16'h00);
    chk("mwrel_state", 16'(state), 16'd1);
    tick(1);
    chk("mwend_state", 16'(state), 16'd0);
    chk("mwend_stall", 16'(stall_cnt), 16'd3);
    chk("mwend_tmo", 16'(mem_timeout), 16'd0);
    m_req = 1'b0; m_ready = 1'b0;

    // Memory wait timeout
    m_req = 1'b1;
    tick(3);
    chk("to3_state", 16'(state), 16'd1);
    chk("to3_tmo", 16'(mem_timeout), 16'd0);
    tick(1);
    chk("to4_state", 16'(state), 16'd2);
    chk("to4_tmo", 16'(mem_timeout), 16'd1);
    chk("to4_halted", 16'(halted), 16'd1);
    chk("to4_stall", 16'(stall_cnt), 16'd7);
    chk("halt_ctl", 16'(ctl), 16'b11111_001);
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; m_ready = 1'b1;
    #1;
    chk("halt_ctl2", 16'(ctl), 16'b11111_001);
    tick(1);
    chk("halt_state", 16'(state), 16'd2);
    chk("halt_stall", 16'(stall_cnt), 16'd7);
    chk("halt_lu", 16'(lu_cnt), 16'd0);
    clr_cnt = 1'b1;
    tick(1);
    chk("halt_clr", 16'(stall_cnt), 16'd0);
    clr_cnt = 1'b0;

    // Reset pulse leaves HALTED
    rst_n = 1'b0;
    #1;
    chk("rst2_ctl", 16'(ctl), 16'h00);
    chk("rst2_state", 16'(state), 16'd0);
    chk("rst2_flags", 16'({halted, mem_timeout}), 16'd0);
    set_idle();
    #3;
    rst_n = 1'b1;
    tick(1);

    // W exception beats the memory freeze
    W_stat = 3'd3; m_req = 1'b1; m_ready = 1'b0;
    #1;
    chk("excw_ctl", 16'(ctl), 16'b00001_001);
    chk("excw_state", 16'(state), 16'd0);
    tick(1);
    chk("excw_next", 16'(state), 16'd2);
    chk("excw_halted", 16'(halted), 16'd1);
    chk("excw_tmo", 16'(mem_timeout), 16'd0);
    m_stat = 3'd3; E_icode = 4'h7; e_Cnd = 1'b0; W_stat = 3'd1;
    #1;
    chk("excw_hold", 16'(ctl), 16'b11111_001);
    tick(1);
    chk("excw_mp", 16'(mp_cnt), 16'd0);
    chk("excw_stay", 16'(state), 16'd2);

    rst_n = 1'b0;
    set_idle();
    #3;
    rst_n = 1'b1;
    tick(1);

    // Saturation and clear priority
    E_icode = 4'hB; E_dstM = 4'h2; d_srcB = 4'h2;
    tick(20);
    chk("sat_lu", 16'(lu_cnt), 16'd15);
    chk("sat_stall", 16'(stall_cnt), 16'd15);
    clr_cnt = 1'b1;
    tick(1);
    chk("clrpri_lu", 16'(lu_cnt), 16'd0);
    clr_cnt = 1'b0;
    tick(1);
    chk("after_clr_lu", 16'(lu_cnt), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
